// File: rtl/axi4l_uart_regs_if.sv
// AXI4-Lite bus bundle between an initiator (master) and the UART register block (slave).
interface axi4l_uart_regs_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_uart_regs.sv
// AXI4-Lite responder exposing TX_DATA/RX_DATA/STATUS/CTRL of a UART core in a 16-byte window.
// Write and read channels run independent two-state FSMs with one outstanding transaction each.
module axi4l_uart_regs #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    axi4l_uart_regs_if.slave          s,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic [AXI_DATA_WIDTH-1:0] ctrl
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] REG_TX      = 2'd0;
    localparam logic [1:0] REG_RX      = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // {hit, register index}; the subtraction wraps so addresses below the base miss too
    function automatic logic [2:0] decode(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = addr - BASE_ADDR;
        return {off < AW'(16), off[3:2]};
    endfunction

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t             wr_state_q;
    logic                  awready_q, wready_q, aw_have_q, w_have_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [AW-1:0]         awaddr_q;
    logic [DW-1:0]         wdata_q;
    logic [NB-1:0]         wstrb_q;
    logic                  tx_valid_q;
    logic [7:0]            tx_data_q;
    logic [NB-1:0][7:0]    ctrl_q;

    rd_state_t             rd_state_q;
    logic                  arready_q, rvalid_q;
    logic [1:0]            rresp_q;
    logic [DW-1:0]         rdata_q;

    logic                  aw_hs, w_hs, wr_commit, tx_free, tx_push, ctrl_we, wr_err;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;
    logic [NB-1:0]         wr_strb;
    logic [2:0]            wr_dec;

    logic                  ar_hs;
    logic [2:0]            rd_dec;
    logic [DW-1:0]         rd_mux;
    logic [1:0]            rd_resp_mux;

    // Address and data may arrive in either order; the latched copy wins once held
    assign aw_hs     = s.awvalid & awready_q;
    assign w_hs      = s.wvalid & wready_q;
    assign wr_addr   = aw_have_q ? awaddr_q : s.awaddr;
    assign wr_data   = w_have_q ? wdata_q : s.wdata;
    assign wr_strb   = w_have_q ? wstrb_q : s.wstrb;
    assign wr_commit = (wr_state_q == W_IDLE) & (aw_have_q | aw_hs) & (w_have_q | w_hs);
    assign wr_dec    = decode(wr_addr);

    // The holding register counts as free if it is draining in this very cycle
    assign tx_free = ~tx_valid_q | tx_ready;
    assign tx_push = wr_commit & wr_dec[2] & (wr_dec[1:0] == REG_TX) & wr_strb[0] & tx_free;
    assign ctrl_we = wr_commit & wr_dec[2] & (wr_dec[1:0] == REG_CTRL);
    assign wr_err  = ~wr_dec[2]
                   | (wr_dec[1:0] == REG_RX)
                   | (wr_dec[1:0] == REG_STATUS)
                   | ((wr_dec[1:0] == REG_TX) & wr_strb[0] & ~tx_free);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            if (tx_push) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= wr_data[7:0];
            end else if (tx_valid_q && tx_ready) begin
                tx_valid_q <= 1'b0;
            end

            case (wr_state_q)
                W_IDLE: begin
                    if (wr_commit) begin
                        wr_state_q <= W_RESP;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        aw_have_q  <= 1'b0;
                        w_have_q   <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            awaddr_q  <= s.awaddr;
                            aw_have_q <= 1'b1;
                            awready_q <= 1'b0;
                        end else begin
                            awready_q <= ~aw_have_q;
                        end
                        if (w_hs) begin
                            wdata_q  <= s.wdata;
                            wstrb_q  <= s.wstrb;
                            w_have_q <= 1'b1;
                            wready_q <= 1'b0;
                        end else begin
                            wready_q <= ~w_have_q;
                        end
                    end
                end
                W_RESP: begin
                    if (s.bready) begin
                        wr_state_q <= W_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_ctrl
        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl_q[gi] <= 8'h00;
            end else if (ctrl_we && wr_strb[gi]) begin
                ctrl_q[gi] <= wr_data[gi*8 +: 8];
            end
        end
    end

    assign ar_hs  = s.arvalid & arready_q;
    assign rd_dec = decode(s.araddr);

    // Reads sample current register state, so a same-cycle write is not yet visible
    always_comb begin
        rd_mux      = '0;
        rd_resp_mux = RESP_OKAY;
        if (!rd_dec[2]) begin
            rd_resp_mux = RESP_SLVERR;
        end else begin
            case (rd_dec[1:0])
                REG_TX:     rd_resp_mux = RESP_SLVERR;
                REG_RX:     rd_mux[7:0] = rx_valid ? rx_data : 8'h00;
                REG_STATUS: rd_mux[1:0] = {rx_valid, tx_valid_q};
                default:    rd_mux      = ctrl_q;
            endcase
        end
    end

    assign rx_ready = ar_hs & rd_dec[2] & (rd_dec[1:0] == REG_RX) & rx_valid & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state_q <= R_DATA;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_mux;
                        rresp_q    <= rd_resp_mux;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s.rready) begin
                        rd_state_q <= R_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rresp   = rresp_q;
    assign s.rdata   = rdata_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign ctrl      = ctrl_q;
endmodule
